// File: rtl/pixel_coord_gen.sv
// Raster coordinate generator: walks (x,y) over one SCREEN_WIDTH x SCREEN_HEIGHT frame
// per start request, presenting one coordinate per accepted valid/ready handshake.
`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 4
`endif
`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 3
`endif

module pixel_coord_gen #(
  parameter int unsigned SCREEN_WIDTH  = `SCREEN_WIDTH,
  parameter int unsigned SCREEN_HEIGHT = `SCREEN_HEIGHT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        coords_ready,
  output logic [31:0] screen_x,
  output logic [31:0] screen_y,
  output logic        coords_valid,
  output logic        sof,
  output logic        eol,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_count
);

  localparam int unsigned XW = $clog2(SCREEN_WIDTH);
  localparam int unsigned YW = $clog2(SCREEN_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  // Coordinates come straight from the counter registers, zero-extended.
  assign screen_x = 32'(x_q);
  assign screen_y = 32'(y_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      coords_valid <= 1'b0;
      sof          <= 1'b0;
      eol          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      frame_count  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state        <= SCAN;
            x_q          <= '0;
            y_q          <= '0;
            coords_valid <= 1'b1;
            busy         <= 1'b1;
            sof          <= 1'b1;
            eol          <= 1'b0;
          end
        end
        SCAN: begin
          // Everything holds while the consumer stalls.
          if (coords_ready) begin
            sof <= 1'b0;
            if (x_q == X_LAST) begin
              x_q <= '0;
              eol <= 1'b0;
              if (y_q == Y_LAST) begin
                state        <= DONE;
                y_q          <= '0;
                coords_valid <= 1'b0;
                busy         <= 1'b0;
                done         <= 1'b1;
                frame_count  <= frame_count + 16'd1;
              end else begin
                y_q <= y_q + YW'(1);
              end
            end else begin
              x_q <= x_q + XW'(1);
              eol <= ((x_q + XW'(1)) == X_LAST);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
